orb_pingpong_packer: RTL and testbench

N-channel orbit-frame packer for the M16 telemetry path. It drains byte-wide LCB receive FIFOs round-robin and converts each byte into an orbit word. Each word is written into the idle half of a ping-pong frame RAM pair, while the frame reader consumes the other half. It generalises the fixed two-channel packer to CH channels with parametrised word width, address width and per-frame channel quotas, and adds overflow reporting and bank-coherent frame swap.

---
 rtl/orb_pingpong_packer.sv | 159 +++++++++++++++
 tb/tb_orb_pingpong_packer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/orb_pingpong_packer.sv
// Round-robin LCB byte drainer that packs parity-tagged orbit words into the idle
// half of a ping-pong frame RAM, with per-channel quotas and bank-coherent swap.
module orb_pingpong_packer #(
    parameter int CH     = 4,
    parameter int WORD_W = 12,
    parameter int ADDR_W = 11,
    parameter int QUOTA  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iSW,
    input  logic [CH-1:0]        iEmpty,
    input  logic [8*CH-1:0]      iData,
    input  logic [ADDR_W*CH-1:0] iBase,
    output logic [CH-1:0]        oRd,
    output logic [ADDR_W-1:0]    oWrAddr,
    output logic [WORD_W-1:0]    oWrData,
    output logic                 oWE1,
    output logic                 oWE2,
    input  logic [ADDR_W-1:0]    iRdAddr,
    input  logic                 iRE,
    output logic [ADDR_W-1:0]    oRdAddr1,
    output logic [ADDR_W-1:0]    oRdAddr2,
    output logic                 oRE1,
    output logic                 oRE2,
    input  logic [WORD_W-1:0]    iMem1,
    input  logic [WORD_W-1:0]    iMem2,
    output logic [WORD_W-1:0]    oOrbData,
    output logic [CH-1:0]        oOvf
);
    localparam int CNT_W = $clog2(QUOTA + 1);
    localparam int SEL_W = $clog2(CH);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_LATCH, S_WR} state_t;

    state_t               r_state, w_next;
    logic [SEL_W-1:0]     r_sel, r_ptr, w_pick;
    logic                 w_any;
    logic                 r_swQ, w_swEdge;
    logic [CNT_W-1:0]     r_cnt [CH];
    logic [CH-1:0]        r_ovf;
    logic                 r_weArm;
    logic [ADDR_W-1:0]    r_wrAddr;
    logic [WORD_W-1:0]    r_wrData;
    logic [WORD_W-1:0]    r_orb;
    logic [7:0]           w_byte;
    logic [ADDR_W-1:0]    w_base;
    logic [CNT_W-1:0]     w_cnt;
    logic                 w_full;
    logic                 w_rdBank1;

    assign w_swEdge = iSW ^ r_swQ;

    // First non-empty channel at or after the pointer; scanning downward lets the smallest offset win.
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_ptr;
        for (int i = CH - 1; i >= 0; i--) begin
            if (!iEmpty[(int'(r_ptr) + i) % CH]) begin
                w_any  = 1'b1;
                w_pick = SEL_W'((int'(r_ptr) + i) % CH);
            end
        end
    end

    always_comb begin
        w_byte = 8'd0;
        w_base = '0;
        w_cnt  = '0;
        for (int k = 0; k < CH; k++) begin
            if (r_sel == SEL_W'(k)) begin
                w_byte = iData[8*k +: 8];
                w_base = iBase[ADDR_W*k +: ADDR_W];
                w_cnt  = r_cnt[k];
            end
        end
        w_full = (w_cnt >= CNT_W'(QUOTA));
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next = S_RD;
            S_RD:    w_next = S_LATCH;
            S_LATCH: w_next = S_WR;
            S_WR:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_sel    <= '0;
            r_ptr    <= '0;
            r_swQ    <= 1'b0;
            r_weArm  <= 1'b0;
            r_wrAddr <= '0;
            r_wrData <= '0;
            r_orb    <= '0;
        end else begin
            r_state <= w_next;
            r_swQ   <= iSW;
            r_orb   <= r_swQ ? iMem2 : iMem1;
            case (r_state)
                S_IDLE:  if (w_any) r_sel <= w_pick;
                S_LATCH: begin
                    r_weArm <= !w_full;
                    if (!w_full) begin
                        r_wrAddr <= w_base + ADDR_W'(w_cnt);
                        r_wrData <= WORD_W'({~^w_byte, w_byte});
                    end
                end
                S_WR:    r_ptr <= (int'(r_sel) == CH - 1) ? '0 : r_sel + 1'b1;
                default: ;
            endcase
        end
    end

    // Frame swap clears quotas and overflow flags, overriding any same-cycle update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < CH; k++) r_cnt[k] <= '0;
            r_ovf <= '0;
        end else begin
            for (int k = 0; k < CH; k++) begin
                if (w_swEdge) begin
                    r_cnt[k] <= '0;
                    r_ovf[k] <= 1'b0;
                end else if (r_sel == SEL_W'(k)) begin
                    if (r_state == S_WR && r_weArm && r_cnt[k] < CNT_W'(QUOTA))
                        r_cnt[k] <= r_cnt[k] + 1'b1;
                    if (r_state == S_LATCH && w_full)
                        r_ovf[k] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        oRd = '0;
        if (r_state == S_RD) oRd[r_sel] = 1'b1;
    end

    // Write enable follows the registered bank select, so a WR on the swap edge still hits the old bank.
    assign oWE1     = (r_state == S_WR) && r_weArm && r_swQ;
    assign oWE2     = (r_state == S_WR) && r_weArm && !r_swQ;
    assign oWrAddr  = r_wrAddr;
    assign oWrData  = r_wrData;
    assign oOvf     = r_ovf;
    assign oOrbData = r_orb;

    assign w_rdBank1 = rst && !r_swQ;
    assign oRE1      = w_rdBank1 && iRE;
    assign oRE2      = rst && r_swQ && iRE;
    assign oRdAddr1  = w_rdBank1 ? iRdAddr : '0;
    assign oRdAddr2  = (rst && r_swQ) ? iRdAddr : '0;

endmodule

// File: tb/tb_orb_pingpong_packer.sv
// Randomized scoreboard bench for orb_pingpong_packer: FIFO responder, write monitor,
// and a transaction-level round-robin/quota model.
module tb_orb_pingpong_packer;
    localparam int CH = 4, WORD_W = 12, ADDR_W = 11, QUOTA = 4;

    logic clk = 1'b0;
    logic rst, iSW, iRE, oWE1, oWE2, oRE1, oRE2;
    logic [CH-1:0] iEmpty, oRd, oOvf;
    logic [8*CH-1:0] iData;
    logic [ADDR_W*CH-1:0] iBase;
    logic [ADDR_W-1:0] oWrAddr, iRdAddr, oRdAddr1, oRdAddr2;
    logic [WORD_W-1:0] oWrData, iMem1, iMem2, oOrbData;

    orb_pingpong_packer #(.CH(CH), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .QUOTA(QUOTA)) dut (
        .clk(clk), .rst(rst), .iSW(iSW), .iEmpty(iEmpty), .iData(iData), .iBase(iBase),
        .oRd(oRd), .oWrAddr(oWrAddr), .oWrData(oWrData), .oWE1(oWE1), .oWE2(oWE2),
        .iRdAddr(iRdAddr), .iRE(iRE), .oRdAddr1(oRdAddr1), .oRdAddr2(oRdAddr2),
        .oRE1(oRE1), .oRE2(oRE2), .iMem1(iMem1), .iMem2(iMem2), .oOrbData(oOrbData), .oOvf(oOvf));

    always #5 clk = ~clk;

    typedef struct { int bank; logic [ADDR_W-1:0] addr; logic [WORD_W-1:0] data; } ex_t;
    ex_t exq[$];

    int n_cmp = 0, n_bad = 0;
    logic [7:0] fb [CH][256];
    int wp [CH];
    int rp [CH];
    int mcnt [CH];
    bit movf [CH];
    int mptr;
    logic [ADDR_W-1:0] base [CH];
    int nbv [CH];
    int fixb;

    for (genvar g = 0; g < CH; g++) begin : g_empty
        assign iEmpty[g] = (wp[g] == rp[g]);
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // FIFO responder: non-showahead, q valid one cycle after rdreq.
    initial begin
        int pend;
        pend = -1;
        iData = '0;
        forever begin
            @(posedge clk); #1;
            if (pend >= 0) begin
                check("rd_nonempty", rp[pend] < wp[pend], 1);
                iData[8*pend +: 8] = fb[pend][rp[pend] % 256];
                rp[pend]++;
            end
            pend = -1;
            for (int k = 0; k < CH; k++) if (oRd[k]) pend = k;
            if (oRd != '0) check("rd_onehot", $countones(oRd) == 1, 1);
        end
    end

    // Write monitor.
    initial begin
        ex_t e;
        forever begin
            @(negedge clk);
            if (oWE1 && oWE2) check("we_both", 1, 0);
            else if (oWE1 || oWE2) begin
                if (exq.size() == 0) check("unexpected_write", {oWE1, oWE2}, 0);
                else begin
                    e = exq.pop_front();
                    check("wr_bank", oWE1 ? 1 : 2, e.bank);
                    check("wr_addr", oWrAddr, e.addr);
                    check("wr_data", oWrData, e.data);
                end
            end
        end
    end

    task automatic drive_bases();
        for (int k = 0; k < CH; k++) iBase[ADDR_W*k +: ADDR_W] = base[k];
    endtask

    // Loads nbv[k] bytes per channel at once and predicts the resulting write sequence.
    task automatic load_batch();
        logic [7:0] lq [CH][8];
        int taken [CH];
        int total, k;
        logic [7:0] b;
        ex_t e;
        total = 0;
        for (int c = 0; c < CH; c++) begin
            taken[c] = 0;
            for (int j = 0; j < nbv[c]; j++) begin
                lq[c][j] = (fixb >= 0) ? 8'(fixb) : 8'($urandom);
                fb[c][(wp[c] + j) % 256] = lq[c][j];
            end
            total += nbv[c];
        end
        for (int n = 0; n < total; n++) begin
            k = mptr;
            for (int off = CH - 1; off >= 0; off--)
                if (taken[(mptr + off) % CH] < nbv[(mptr + off) % CH]) k = (mptr + off) % CH;
            b = lq[k][taken[k]];
            taken[k]++;
            if (mcnt[k] < QUOTA) begin
                e.bank = iSW ? 1 : 2;
                e.addr = ADDR_W'(int'(base[k]) + mcnt[k]);
                e.data = WORD_W'({~^b, b});
                exq.push_back(e);
                mcnt[k]++;
            end else movf[k] = 1'b1;
            mptr = (k + 1) % CH;
        end
        for (int c = 0; c < CH; c++) wp[c] += nbv[c];
    endtask

    task automatic drain();
        int c;
        bit busy;
        c = 0;
        busy = 1'b1;
        while (busy && c < 500) begin
            busy = (exq.size() != 0);
            for (int k = 0; k < CH; k++) if (rp[k] != wp[k]) busy = 1'b1;
            if (busy) begin @(posedge clk); c++; end
        end
        if (busy) check("drain_timeout", 1, 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_ovf(string name);
        logic [CH-1:0] mv;
        for (int k = 0; k < CH; k++) mv[k] = movf[k];
        check(name, oOvf, mv);
    endtask

    task automatic clear_model();
        for (int k = 0; k < CH; k++) begin mcnt[k] = 0; movf[k] = 1'b0; end
    endtask

    task automatic swap();
        iSW = ~iSW;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check("ovf_after_swap", oOvf, 0);
    endtask

    task automatic readcheck();
        logic [WORD_W-1:0] exp;
        iRdAddr = ADDR_W'($urandom);
        iRE = 1'($urandom);
        iMem1 = WORD_W'($urandom);
        iMem2 = WORD_W'($urandom);
        #1;
        if (!iSW) begin
            check("rdaddr1", oRdAddr1, iRdAddr); check("re1", oRE1, iRE);
            check("re2_off", oRE2, 0); check("rdaddr2_off", oRdAddr2, 0);
            exp = iMem1;
        end else begin
            check("rdaddr2", oRdAddr2, iRdAddr); check("re2", oRE2, iRE);
            check("re1_off", oRE1, 0); check("rdaddr1_off", oRdAddr1, 0);
            exp = iMem2;
        end
        @(posedge clk); #1;
        check("orbdata", oOrbData, exp);
    endtask

    task automatic check_reset_outputs();
        check("rst_oRd", oRd, 0); check("rst_oWE", {oWE1, oWE2}, 0);
        check("rst_wraddr", oWrAddr, 0); check("rst_wrdata", oWrData, 0);
        check("rst_ovf", oOvf, 0); check("rst_re", {oRE1, oRE2}, 0);
        check("rst_rdaddr", {oRdAddr1, oRdAddr2}, 0); check("rst_orb", oOrbData, 0);
    endtask

    initial begin
        int c;
        rst = 1'b0; iSW = 1'b0; iRE = 1'b1; iRdAddr = 5; iMem1 = 12'h123; iMem2 = 12'h456;
        fixb = -1; mptr = 0;
        for (int k = 0; k < CH; k++) begin wp[k] = 0; rp[k] = 0; nbv[k] = 0; base[k] = '0; end
        clear_model();
        drive_bases();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Single byte on channel 2.
        base[2] = 100; drive_bases();
        nbv[2] = 1; fixb = 8'h5A; load_batch(); fixb = -1; nbv[2] = 0;
        @(posedge clk); #1;
        check("single_oRd", oRd, 4'b0100);
        drain();

        // Randomized batches with occasional frame swaps and read-path checks.
        for (int it = 0; it < 14; it++) begin
            for (int k = 0; k < CH; k++) begin
                base[k] = ADDR_W'($urandom);
                nbv[k] = $urandom_range(0, 3);
            end
            drive_bases();
            load_batch();
            drain();
            check_ovf("ovf_batch");
            readcheck();
            if ($urandom_range(0, 2) == 0) swap();
        end

        // Quota overflow on channel 0.
        swap();
        for (int k = 0; k < CH; k++) nbv[k] = 0;
        nbv[0] = QUOTA + 1; load_batch(); nbv[0] = 0;
        drain();
        check("quota_ovf", oOvf, 4'b0001);
        check_ovf("quota_model");

        // Swap lands on the WR cycle of a channel-1 word.
        nbv[1] = 1; load_batch();
        c = 0;
        do begin @(posedge clk); #1; c++; end while (!(oWE1 || oWE2) && c < 50);
        if (c >= 50) check("race_wr_timeout", 1, 0);
        iSW = ~iSW;
        clear_model();
        drain();
        check("race_ovf_clear", oOvf, 0);
        load_batch(); nbv[1] = 0;
        drain();
        readcheck();

        // Asynchronous reset while RD is presented.
        fb[3][wp[3] % 256] = 8'hC3; wp[3]++;
        c = 0;
        do begin @(posedge clk); #1; c++; end while (oRd == '0 && c < 50);
        if (c >= 50) check("rst_rd_timeout", 1, 0);
        #1 rst = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        clear_model(); mptr = 0;
        repeat (4) @(posedge clk);
        #1;
        check("post_rst_no_we", {oWE1, oWE2}, 0);

        // Address wrap: base 2046 over four words.
        base[0] = 2046; drive_bases();
        nbv[0] = 4; load_batch(); nbv[0] = 0;
        drain();
        check("wrap_last_addr", oWrAddr, 1);
        check("final_queue_empty", exq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
